flow_ctrl_fsm: RTL and testbench

FLOW_CTRL_FSM -- requirements
Module: flow_ctrl_fsm

---
 rtl/flow_ctrl_pkg.sv | 16 +
 rtl/flow_ctrl_ch.sv | 47 ++++
 rtl/flow_ctrl_fsm.sv | 133 +++++++++++++
 tb/tb_flow_ctrl_fsm.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/flow_ctrl_pkg.sv
// Shared state encoding and default thresholds for the FIFO flow-control FSM.
package flow_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_PAUSE  = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  localparam int DEF_HI_THR = 6;
  localparam int DEF_LO_THR = 2;

endpackage

// File: rtl/flow_ctrl_ch.sv
// One FIFO channel: pause flag with hysteresis and a sticky error/full bit.
module flow_ctrl_ch #(
  parameter int DEPTH = 8,
  parameter int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             err_clear,
  input  logic [OCC_W-1:0] occ,
  input  logic [OCC_W-1:0] thr_hi,
  input  logic [OCC_W-1:0] thr_lo,
  input  logic             fifo_err,
  output logic             flag_next,
  output logic             err_next,
  output logic             err_set,
  output logic             empty,
  output logic             error_full
);

  logic flag_q;

  // Next values are exported so the FSM can decide on this cycle's sample.
  always_comb begin
    err_set   = fifo_err | (occ == OCC_W'(DEPTH));
    empty     = (occ == '0);
    flag_next = flag_q;
    if (clr)
      flag_next = 1'b0;
    else if (occ >= thr_hi)
      flag_next = 1'b1;
    else if (occ <= thr_lo)
      flag_next = 1'b0;
    err_next = clr ? 1'b0 : (err_set | (error_full & ~err_clear));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flag_q     <= 1'b0;
      error_full <= 1'b0;
    end else begin
      flag_q     <= flag_next;
      error_full <= err_next;
    end
  end

endmodule

// File: rtl/flow_ctrl_fsm.sv
// Flow-control FSM: watches FIFO occupancies and issues per-channel pause/continue.
module flow_ctrl_fsm
  import flow_ctrl_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 8,
  parameter int OCC_W  = $clog2(DEPTH + 1),
  parameter int CNT_W  = 16,
  parameter int DEF_HI = DEF_HI_THR,
  parameter int DEF_LO = DEF_LO_THR
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [OCC_W-1:0]        thr_hi_in,
  input  logic [OCC_W-1:0]        thr_lo_in,
  input  logic [NUM_CH*OCC_W-1:0] occ,
  input  logic [NUM_CH-1:0]       fifo_err,
  input  logic                    err_clr,
  output logic [2:0]              state,
  output logic                    idle,
  output logic [NUM_CH-1:0]       pause,
  output logic [NUM_CH-1:0]       continue_o,
  output logic [NUM_CH-1:0]       error_full,
  output logic                    cfg_err,
  output logic [CNT_W-1:0]        pause_cycles
);

  state_t             state_q, state_next;
  logic [OCC_W-1:0]   thr_hi, thr_lo;
  logic [NUM_CH-1:0]  flag_next, err_next, err_set, empty;
  logic               ch_clr, err_clear, cfg_ok;

  assign state = state_q;

  // Flags and errors only run in the operating states; any path into INIT wipes them.
  assign ch_clr    = init | (state_q == ST_RESET) | (state_q == ST_INIT);
  assign err_clear = (state_q == ST_ERROR) & err_clr & ~(|err_set);
  assign cfg_ok    = (thr_lo_in < thr_hi_in) && (thr_hi_in <= OCC_W'(DEPTH));

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    flow_ctrl_ch #(
      .DEPTH (DEPTH),
      .OCC_W (OCC_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .clr        (ch_clr),
      .err_clear  (err_clear),
      .occ        (occ[i*OCC_W +: OCC_W]),
      .thr_hi     (thr_hi),
      .thr_lo     (thr_lo),
      .fifo_err   (fifo_err[i]),
      .flag_next  (flag_next[i]),
      .err_next   (err_next[i]),
      .err_set    (err_set[i]),
      .empty      (empty[i]),
      .error_full (error_full[i])
    );
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      ST_RESET: state_next = init ? ST_INIT : ST_RESET;
      ST_INIT:  state_next = init ? ST_INIT : ST_IDLE;
      ST_IDLE, ST_ACTIVE, ST_PAUSE, ST_ERROR: begin
        if (init)
          state_next = ST_INIT;
        else if (|err_next)
          state_next = ST_ERROR;
        else begin
          case (state_q)
            ST_IDLE:   state_next = (&empty) ? ST_IDLE : ST_ACTIVE;
            ST_ACTIVE: begin
              if (|flag_next)
                state_next = ST_PAUSE;
              else if (&empty)
                state_next = ST_IDLE;
            end
            ST_PAUSE: begin
              if (!(|flag_next))
                state_next = (&empty) ? ST_IDLE : ST_ACTIVE;
            end
            default:   state_next = ST_IDLE;
          endcase
        end
      end
      default: state_next = ST_RESET;
    endcase
  end

  // Outputs are derived from the next state so they land in the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RESET;
      thr_hi       <= OCC_W'(DEF_HI);
      thr_lo       <= OCC_W'(DEF_LO);
      idle         <= 1'b0;
      pause        <= '0;
      continue_o   <= '0;
      cfg_err      <= 1'b0;
      pause_cycles <= '0;
    end else begin
      state_q <= state_next;
      idle    <= (state_next == ST_IDLE);
      cfg_err <= (state_q == ST_INIT) && !cfg_ok;
      if ((state_q == ST_INIT) && cfg_ok) begin
        thr_hi <= thr_hi_in;
        thr_lo <= thr_lo_in;
      end
      case (state_next)
        ST_ACTIVE, ST_PAUSE: begin
          pause      <= flag_next;
          continue_o <= ~flag_next;
        end
        ST_ERROR: begin
          pause      <= '1;
          continue_o <= '0;
        end
        default: begin
          pause      <= '0;
          continue_o <= '0;
        end
      endcase
      if (state_next == ST_INIT)
        pause_cycles <= '0;
      else if ((state_next == ST_PAUSE) && (pause_cycles != '1))
        pause_cycles <= pause_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_flow_ctrl_fsm.sv
// Scoreboard bench for flow_ctrl_fsm: directed vectors queue expectations, a monitor checks them.
module tb_flow_ctrl_fsm;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 8;
  localparam int OCC_W  = 4;
  localparam int CNT_W  = 3;

  localparam logic [2:0] S_RST = 3'd0, S_INI = 3'd1, S_IDL = 3'd2,
                         S_ACT = 3'd3, S_PAU = 3'd4, S_ERR = 3'd5;

  typedef struct packed {
    logic [2:0]       st;
    logic             idle;
    logic [3:0]       pause;
    logic [3:0]       cont;
    logic [3:0]       errf;
    logic             cfg;
    logic [CNT_W-1:0] pc;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    init = 1'b0;
  logic [OCC_W-1:0]        thr_hi_in = '0;
  logic [OCC_W-1:0]        thr_lo_in = '0;
  logic [NUM_CH*OCC_W-1:0] occ = '0;
  logic [NUM_CH-1:0]       fifo_err = '0;
  logic                    err_clr = 1'b0;
  logic [2:0]              state;
  logic                    idle;
  logic [NUM_CH-1:0]       pause;
  logic [NUM_CH-1:0]       continue_o;
  logic [NUM_CH-1:0]       error_full;
  logic                    cfg_err;
  logic [CNT_W-1:0]        pause_cycles;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  flow_ctrl_fsm #(
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .thr_hi_in    (thr_hi_in),
    .thr_lo_in    (thr_lo_in),
    .occ          (occ),
    .fifo_err     (fifo_err),
    .err_clr      (err_clr),
    .state        (state),
    .idle         (idle),
    .pause        (pause),
    .continue_o   (continue_o),
    .error_full   (error_full),
    .cfg_err      (cfg_err),
    .pause_cycles (pause_cycles)
  );

  task automatic apply_stimulus(input string nm, input logic rst, input logic ini,
                                input logic [3:0] hi, input logic [3:0] lo,
                                input logic [15:0] oc, input logic [3:0] fe, input logic ec,
                                input logic [2:0] st, input logic idl, input logic [3:0] pse,
                                input logic [3:0] cnt, input logic [3:0] ef, input logic cf,
                                input logic [CNT_W-1:0] pcv);
    exp_t e;
    reset = rst; init = ini; thr_hi_in = hi; thr_lo_in = lo;
    occ = oc; fifo_err = fe; err_clr = ec;
    @(posedge clk);
    e = '{st: st, idle: idl, pause: pse, cont: cnt, errf: ef, cfg: cf, pc: pcv};
    exp_q.push_back(e);
    name_q.push_back(nm);
    #1;
  endtask

  task automatic check_output(input string nm, input exp_t e);
    exp_t g;
    g = '{st: state, idle: idle, pause: pause, cont: continue_o, errf: error_full,
          cfg: cfg_err, pc: pause_cycles};
    n_vec++;
    if (g !== e) begin
      n_err++;
      $display("[TB] FAIL %s: got st=%0d idle=%0b pause=%h cont=%h errf=%h cfg=%0b pc=%0d, want st=%0d idle=%0b pause=%h cont=%h errf=%h cfg=%0b pc=%0d",
               nm, g.st, g.idle, g.pause, g.cont, g.errf, g.cfg, g.pc,
               e.st, e.idle, e.pause, e.cont, e.errf, e.cfg, e.pc);
    end
  endtask

  // Monitor: one expectation is consumed per clock, away from the sampling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0)
        check_output(name_q.pop_front(), exp_q.pop_front());
    end
  end

  initial begin
    // Reset, including overriding init/fifo_err/err_clr
    apply_stimulus("rst",            1,0,5,1,16'h0000,4'h0,0, S_RST,0,4'h0,4'h0,4'h0,0,0);
    apply_stimulus("rst_override",   1,1,5,1,16'h8888,4'hF,1, S_RST,0,4'h0,4'h0,4'h0,0,0);
    // Configuration
    apply_stimulus("to_init",        0,1,5,1,16'h0000,4'h0,0, S_INI,0,4'h0,4'h0,4'h0,0,0);
    apply_stimulus("load_5_1",       0,1,5,1,16'h0000,4'h0,0, S_INI,0,4'h0,4'h0,4'h0,0,0);
    apply_stimulus("reject_3_3",     0,1,3,3,16'h0000,4'h0,0, S_INI,0,4'h0,4'h0,4'h0,1,0);
    apply_stimulus("leave_init",     0,0,3,3,16'h0000,4'h0,0, S_IDL,1,4'h0,4'h0,4'h0,1,0);
    apply_stimulus("idle_hold",      0,0,3,3,16'h0000,4'h0,0, S_IDL,1,4'h0,4'h0,4'h0,0,0);
    // Hysteresis with thresholds 5/1
    apply_stimulus("occ2",           0,0,3,3,16'h0002,4'h0,0, S_ACT,0,4'h0,4'hF,4'h0,0,0);
    apply_stimulus("occ5",           0,0,3,3,16'h0005,4'h0,0, S_PAU,0,4'h1,4'hE,4'h0,0,1);
    apply_stimulus("occ3",           0,0,3,3,16'h0003,4'h0,0, S_PAU,0,4'h1,4'hE,4'h0,0,2);
    apply_stimulus("occ1",           0,0,3,3,16'h0001,4'h0,0, S_ACT,0,4'h0,4'hF,4'h0,0,2);
    apply_stimulus("occ4",           0,0,3,3,16'h0004,4'h0,0, S_ACT,0,4'h0,4'hF,4'h0,0,2);
    apply_stimulus("occ6",           0,0,3,3,16'h0006,4'h0,0, S_PAU,0,4'h1,4'hE,4'h0,0,3);
    apply_stimulus("occ2_hold",      0,0,3,3,16'h0002,4'h0,0, S_PAU,0,4'h1,4'hE,4'h0,0,4);
    apply_stimulus("drain",          0,0,3,3,16'h0000,4'h0,0, S_IDL,1,4'h0,4'h0,4'h0,0,4);
    // Sticky error
    apply_stimulus("ch1_occ",        0,0,3,3,16'h0010,4'h0,0, S_ACT,0,4'h0,4'hF,4'h0,0,4);
    apply_stimulus("ferr2",          0,0,3,3,16'h0010,4'h4,0, S_ERR,0,4'hF,4'h0,4'h4,0,4);
    apply_stimulus("err_sticky",     0,0,3,3,16'h0010,4'h0,0, S_ERR,0,4'hF,4'h0,4'h4,0,4);
    apply_stimulus("clr_with_ferr1", 0,0,3,3,16'h0010,4'h2,1, S_ERR,0,4'hF,4'h0,4'h6,0,4);
    apply_stimulus("clr_alone",      0,0,3,3,16'h0010,4'h0,1, S_IDL,1,4'h0,4'h0,4'h0,0,4);
    // Full detection
    apply_stimulus("reactivate",     0,0,3,3,16'h0010,4'h0,0, S_ACT,0,4'h0,4'hF,4'h0,0,4);
    apply_stimulus("ch3_full",       0,0,3,3,16'h8010,4'h0,0, S_ERR,0,4'hF,4'h0,4'h8,0,4);
    apply_stimulus("clr_while_full", 0,0,3,3,16'h8010,4'h0,1, S_ERR,0,4'hF,4'h0,4'h8,0,4);
    apply_stimulus("clr_after_full", 0,0,3,3,16'h0000,4'h0,1, S_IDL,1,4'h0,4'h0,4'h0,0,4);
    // Reset in PAUSE
    apply_stimulus("occ6_idle",      0,0,3,3,16'h0006,4'h0,0, S_ACT,0,4'h1,4'hE,4'h0,0,4);
    apply_stimulus("pause_a",        0,0,3,3,16'h0006,4'h0,0, S_PAU,0,4'h1,4'hE,4'h0,0,5);
    apply_stimulus("pause_b",        0,0,3,3,16'h0006,4'h0,0, S_PAU,0,4'h1,4'hE,4'h0,0,6);
    apply_stimulus("rst_in_pause",   1,1,3,3,16'h0006,4'hF,1, S_RST,0,4'h0,4'h0,4'h0,0,0);
    // Re-init from ACTIVE
    apply_stimulus("reinit",         0,1,3,3,16'h0006,4'h0,0, S_INI,0,4'h0,4'h0,4'h0,0,0);
    apply_stimulus("reload_5_1",     0,1,5,1,16'h0006,4'h0,0, S_INI,0,4'h0,4'h0,4'h0,0,0);
    apply_stimulus("idle2",          0,0,5,1,16'h0000,4'h0,0, S_IDL,1,4'h0,4'h0,4'h0,0,0);
    apply_stimulus("occ5b",          0,0,5,1,16'h0005,4'h0,0, S_ACT,0,4'h1,4'hE,4'h0,0,0);
    apply_stimulus("pause_c",        0,0,5,1,16'h0005,4'h0,0, S_PAU,0,4'h1,4'hE,4'h0,0,1);
    apply_stimulus("pause_d",        0,0,5,1,16'h0005,4'h0,0, S_PAU,0,4'h1,4'hE,4'h0,0,2);
    apply_stimulus("occ1b",          0,0,5,1,16'h0001,4'h0,0, S_ACT,0,4'h0,4'hF,4'h0,0,2);
    apply_stimulus("init_in_active", 0,1,5,1,16'h0005,4'h0,0, S_INI,0,4'h0,4'h0,4'h0,0,0);
    apply_stimulus("init_exit",      0,0,5,1,16'h0003,4'h0,0, S_IDL,1,4'h0,4'h0,4'h0,0,0);
    apply_stimulus("occ3_active",    0,0,5,1,16'h0003,4'h0,0, S_ACT,0,4'h0,4'hF,4'h0,0,0);
    // Counter saturation at 2^3-1
    for (int k = 1; k <= 10; k++)
      apply_stimulus($sformatf("sat_%0d", k), 0,0,5,1,16'h0007,4'h0,0,
                     S_PAU,0,4'h1,4'hE,4'h0,0, CNT_W'((k < 7) ? k : 7));
    // Reset in ERROR
    apply_stimulus("ferr_in_pause",  0,0,5,1,16'h0007,4'h1,0, S_ERR,0,4'hF,4'h0,4'h1,0,7);
    apply_stimulus("rst_in_error",   1,1,5,1,16'h0007,4'hF,1, S_RST,0,4'h0,4'h0,4'h0,0,0);
    apply_stimulus("post_rst_hold",  0,0,5,1,16'h0000,4'h0,0, S_RST,0,4'h0,4'h0,4'h0,0,0);

    for (int w = 0; w < 20 && exp_q.size() > 0; w++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("[TB] FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
